modulo_controle_contador_5_bits: RTL and testbench

Command-side controller for the 5-bit synchronous up/down counter. Turns three raw push-button/sensor inputs (count up, count down, load) into the counter's single-cycle `enable`, `up_down`, `load` and `e_load` commands. Reads the counter's `q` back to enforce capacity limits and to flag full, empty and rejected requests. Sits between the board inputs and the counter in the occupancy-counting datapath.

---
 rtl/modulo_controle_pkg.sv | 16 +
 rtl/modulo_debounce.sv | 61 ++++++
 rtl/modulo_controle_contador_5_bits.sv | 110 +++++++++++
 tb/tb_modulo_controle_contador_5_bits.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/modulo_controle_pkg.sv
// modulo_controle_pkg: shared types and constants for the 5-bit counter command controller
package modulo_controle_pkg;
  localparam int LARGURA_CONT = 5;
  localparam int LARGURA_DEB = 8;
  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    PASSO      = 3'd1,
    ESPERA_Q   = 3'd2,
    CARGA      = 3'd3,
    CARGA_HOLD = 3'd4
  } estado_t;
  function automatic logic [LARGURA_CONT-1:0] satura(input logic [LARGURA_CONT-1:0] v,
                                                     input logic [LARGURA_CONT-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/modulo_debounce.sv
// modulo_debounce: 2-flop synchronizer, optional debouncer (CTRL_DEBOUNCE_EN) and rising-edge pulse
import modulo_controle_pkg::*;
module modulo_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_bruto,
  output logic o_pulso
);
  logic r_s1;
  logic r_s2;
  logic r_nivel_d;
  logic w_nivel;
`ifdef CTRL_DEBOUNCE_EN
  localparam bit FILTRO = 1'b1;
`else
  localparam bit FILTRO = 1'b0;
`endif
  // bring the asynchronous input into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_bruto;
      r_s2 <= r_s1;
    end
  end
  // a zero cycle count is outside the legal range and degenerates to the direct path
  generate
    if (FILTRO && DEBOUNCE_CYCLES > 0) begin : g_filtro
      localparam logic [LARGURA_DEB-1:0] CNT_FIM = LARGURA_DEB'(DEBOUNCE_CYCLES - 1);
      logic [LARGURA_DEB-1:0] r_cnt;
      logic r_nivel;
      // accept a new level only after it differs from the filtered one for DEBOUNCE_CYCLES samples
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt   <= '0;
          r_nivel <= 1'b0;
        end else if (r_s2 == r_nivel) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_FIM) begin
          r_cnt   <= '0;
          r_nivel <= r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_nivel = r_nivel;
    end else begin : g_direto
      assign w_nivel = r_s2;
    end
  endgenerate
  // previous filtered level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) r_nivel_d <= 1'b0;
    else       r_nivel_d <= w_nivel;
  end
  assign o_pulso = w_nivel & ~r_nivel_d;
endmodule

// File: rtl/modulo_controle_contador_5_bits.sv
// modulo_controle_contador_5_bits: command FSM for the 5-bit up/down counter; debounce via CTRL_DEBOUNCE_EN
import modulo_controle_pkg::*;
module modulo_controle_contador_5_bits #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LIMITE_MAX = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_load,
  input  logic [LARGURA_CONT-1:0] valor_load,
  input  logic [LARGURA_CONT-1:0] q,
  output logic                    up_down,
  output logic                    enable,
  output logic                    load,
  output logic [LARGURA_CONT-1:0] e_load,
  output logic                    cheio,
  output logic                    vazio,
  output logic                    erro
);
  localparam logic [LARGURA_CONT-1:0] W_MAX = LARGURA_CONT'(LIMITE_MAX);
  estado_t r_estado, w_prox;
  logic r_pend_up, r_pend_down, r_pend_load;
  logic w_pend_up, w_pend_down, w_pend_load;
  logic r_up_down, w_up_down;
  logic [LARGURA_CONT-1:0] r_e_load, w_e_load;
  logic r_erro, w_erro;
  logic w_ev_up, w_ev_down, w_ev_load;
  logic w_req_up, w_req_down, w_req_load;
  logic w_no_topo;
  modulo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .i_bruto(btn_up), .o_pulso(w_ev_up)
  );
  modulo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .i_bruto(btn_down), .o_pulso(w_ev_down)
  );
  modulo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_load (
    .clk(clk), .reset(reset), .i_bruto(btn_load), .o_pulso(w_ev_load)
  );
  assign cheio     = (q == W_MAX);
  assign vazio     = (q == '0);
  assign w_no_topo = (q >= W_MAX);
  assign w_req_up   = w_ev_up   | r_pend_up;
  assign w_req_down = w_ev_down | r_pend_down;
  assign w_req_load = w_ev_load | r_pend_load;
  // idle arbitration (load, then up/down) and pending capture while a command is in flight
  always_comb begin
    w_prox      = r_estado;
    w_pend_up   = r_pend_up;
    w_pend_down = r_pend_down;
    w_pend_load = r_pend_load;
    w_up_down   = r_up_down;
    w_e_load    = r_e_load;
    w_erro      = 1'b0;
    if (r_estado == OCIOSO) begin
      w_pend_up   = w_req_up;
      w_pend_down = w_req_down;
      w_pend_load = 1'b0;
      if (w_req_load) begin
        w_prox   = CARGA;
        w_e_load = satura(valor_load, W_MAX);
      end else if (w_req_up && w_req_down) begin
        w_pend_up   = 1'b0;
        w_pend_down = 1'b0;
      end else if (w_req_up) begin
        w_pend_up = 1'b0;
        w_erro    = w_no_topo;
        w_prox    = w_no_topo ? OCIOSO : PASSO;
        w_up_down = w_no_topo ? r_up_down : 1'b1;
      end else if (w_req_down) begin
        w_pend_down = 1'b0;
        w_erro      = vazio;
        w_prox      = vazio ? OCIOSO : PASSO;
        w_up_down   = vazio ? r_up_down : 1'b0;
      end
    end else begin
      w_pend_up   = r_pend_up   | w_ev_up;
      w_pend_down = r_pend_down | w_ev_down;
      w_pend_load = r_pend_load | w_ev_load;
      w_erro      = (w_ev_up & r_pend_up) | (w_ev_down & r_pend_down) | (w_ev_load & r_pend_load);
      w_prox      = (r_estado == PASSO) ? ESPERA_Q : (r_estado == CARGA) ? CARGA_HOLD : OCIOSO;
    end
  end
  // controller state; reset drops any in-flight command and pending requests
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_pend_up   <= 1'b0;
      r_pend_down <= 1'b0;
      r_pend_load <= 1'b0;
      r_up_down   <= 1'b1;
      r_e_load    <= '0;
      r_erro      <= 1'b0;
    end else begin
      r_estado    <= w_prox;
      r_pend_up   <= w_pend_up;
      r_pend_down <= w_pend_down;
      r_pend_load <= w_pend_load;
      r_up_down   <= w_up_down;
      r_e_load    <= w_e_load;
      r_erro      <= w_erro;
    end
  end
  assign enable  = (r_estado == PASSO);
  assign load    = (r_estado == CARGA);
  assign up_down = r_up_down;
  assign e_load  = r_e_load;
  assign erro    = r_erro;
endmodule

// File: tb/tb_modulo_controle_contador_5_bits.sv
// tb_modulo_controle_contador_5_bits: directed self-checking bench for the counter command controller
module tb_modulo_controle_contador_5_bits;
`ifdef CTRL_DEBOUNCE_EN
  localparam int L = 7;
`else
  localparam int L = 3;
`endif
  logic clk = 1'b0;
  logic reset, btn_up, btn_down, btn_load;
  logic [4:0] valor_load, q;
  logic up_down, enable, load, cheio, vazio, erro;
  logic [4:0] e_load;
  logic up_down15, enable15, load15, cheio15, vazio15, erro15;
  logic [4:0] e_load15;
  int checks = 0;
  int errors = 0;
  int n_en, n_ld, n_err;
  always #5 clk = ~clk;
  modulo_controle_contador_5_bits #(.DEBOUNCE_CYCLES(4), .LIMITE_MAX(31)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .valor_load(valor_load), .q(q), .up_down(up_down), .enable(enable), .load(load),
    .e_load(e_load), .cheio(cheio), .vazio(vazio), .erro(erro)
  );
  modulo_controle_contador_5_bits #(.DEBOUNCE_CYCLES(4), .LIMITE_MAX(15)) dut15 (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .valor_load(valor_load), .q(q), .up_down(up_down15), .enable(enable15), .load(load15),
    .e_load(e_load15), .cheio(cheio15), .vazio(vazio15), .erro(erro15)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    n_en  += int'(enable);
    n_ld  += int'(load);
    n_err += int'(erro);
  endtask
  task automatic clr();
    n_en = 0;
    n_ld = 0;
    n_err = 0;
  endtask
  task automatic settle();
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    repeat (12) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    clr();
    reset = 1'b1;
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    valor_load = 5'd0;
    q = 5'd5;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_up_down", 32'(up_down), 1);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_e_load", 32'(e_load), 0);
    chk("rst_erro", 32'(erro), 0);
    chk("rst_cheio", 32'(cheio), 0);
    chk("rst_vazio", 32'(vazio), 0);
    repeat (2) tick();
    // held up press with room to count
    clr();
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == L) begin
        chk("up_latency_enable", 32'(enable), 1);
        chk("up_latency_dir", 32'(up_down), 1);
      end
    end
    settle();
    chk("up_pulses", n_en, 1);
    chk("up_erro", n_err, 0);
    // up rejected at the top, down accepted
    q = 5'd31;
    #1;
    chk("full_cheio", 32'(cheio), 1);
    clr();
    btn_up = 1'b1;
    repeat (10) tick();
    settle();
    chk("full_up_enable", n_en, 0);
    chk("full_up_erro", n_err, 1);
    clr();
    btn_down = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == L) begin
        chk("down_enable", 32'(enable), 1);
        chk("down_dir", 32'(up_down), 0);
      end
    end
    settle();
    chk("down_pulses", n_en, 1);
    // down rejected at zero
    q = 5'd0;
    #1;
    chk("empty_vazio", 32'(vazio), 1);
    clr();
    btn_down = 1'b1;
    repeat (10) tick();
    settle();
    chk("empty_down_enable", n_en, 0);
    chk("empty_down_erro", n_err, 1);
    // load with clamping on the LIMITE_MAX=15 instance
    q = 5'd5;
    valor_load = 5'd20;
    clr();
    btn_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == L) begin
        chk("load_strobe", 32'(load), 1);
        chk("load_value", 32'(e_load), 20);
        chk("load_clamped", 32'(e_load15), 15);
      end
      if (i == L + 1) begin
        chk("load_hold_strobe", 32'(load), 0);
        chk("load_hold_value", 32'(e_load), 20);
      end
      if (i == L + 2) chk("load_hold2_value", 32'(e_load), 20);
    end
    settle();
    chk("load_pulses", n_ld, 1);
    q = 5'd15;
    #1;
    chk("max15_cheio", 32'(cheio15), 1);
    chk("max31_not_cheio", 32'(cheio), 0);
    q = 5'd5;
    // simultaneous up and down cancel silently
    clr();
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (10) tick();
    settle();
    chk("cancel_enable", n_en, 0);
    chk("cancel_erro", n_err, 0);
    clr();
    btn_up = 1'b1;
    repeat (10) tick();
    settle();
    chk("after_cancel_enable", n_en, 1);
    chk("after_cancel_dir", 32'(up_down), 1);
`ifdef CTRL_DEBOUNCE_EN
    // bouncing input never settles long enough
    clr();
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2) == 0;
      tick();
    end
    settle();
    chk("bounce_enable", n_en, 0);
`else
    // second up arrives while busy and executes from pending
    clr();
    for (int n = 1; n <= 12; n++) begin
      btn_up = (n == 1) || (n == 3);
      tick();
      if (n == 3) chk("pend_first_enable", 32'(enable), 1);
      if (n == 6) chk("pend_second_enable", 32'(enable), 1);
    end
    settle();
    chk("pend_enables", n_en, 2);
    chk("pend_erro", n_err, 0);
    // up pending behind two loads, repeat up dropped
    clr();
    for (int n = 1; n <= 12; n++) begin
      btn_load = (n == 1) || (n == 3);
      btn_up = (n == 2) || (n == 5);
      tick();
      if (n == 3) chk("drop_load1", 32'(load), 1);
      if (n == 6) chk("drop_load2", 32'(load), 1);
      if (n == 7) chk("drop_erro", 32'(erro), 1);
      if (n == 9) chk("drop_enable", 32'(enable), 1);
    end
    settle();
    chk("drop_loads", n_ld, 2);
    chk("drop_enables", n_en, 1);
    chk("drop_erros", n_err, 1);
`endif
    // reset during PASSO with a load in flight
    clr();
    btn_up = 1'b1;
    for (int i = 1; i <= L; i++) begin
      tick();
      if (i == L - 1) btn_load = 1'b1;
    end
    chk("mid_enable", 32'(enable), 1);
    reset = 1'b1;
    btn_up = 1'b0;
    btn_load = 1'b0;
    tick();
    chk("mid_reset_enable", 32'(enable), 0);
    chk("mid_reset_dir", 32'(up_down), 1);
    reset = 1'b0;
    settle();
    chk("mid_enables", n_en, 1);
    chk("mid_loads", n_ld, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
